// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, stall/flush strobes and multicycle Execute sequencing.
// Defining HAZ_PERF_EN adds saturating load-stall, multicycle-stall and flush counters.
module hazard_ctrl #(
   parameter int MC_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Ra1D,
   input  logic [3:0]       Ra2D,
   input  logic [3:0]       Ra1E,
   input  logic [3:0]       Ra2E,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       WA3M,
   input  logic [3:0]       WA3W,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             PCSrcD,
   input  logic             PCSrcE,
   input  logic             PCSrcM,
   input  logic             PCSrcW,
   input  logic             BranchTakenE,
   input  logic             MultiCycleE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic             McBusy
`ifdef HAZ_PERF_EN
   ,
   output logic [CNT_W-1:0] LdrStallCnt,
   output logic [CNT_W-1:0] McStallCnt,
   output logic [CNT_W-1:0] FlushCnt
`endif
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam bit         MC_EN = MC_LAT > 1;
   localparam logic [3:0] LOAD  = 4'(MC_LAT > 1 ? MC_LAT - 2 : 0);
   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       ldr_stall, pc_pend, mc_stall;
   // M stage result is newer than W, so it wins; R15 is the PC and never forwarded
   assign ForwardAE = (RegWriteM && WA3M == Ra1E && Ra1E != 4'd15) ? 2'b10 :
                      (RegWriteW && WA3W == Ra1E && Ra1E != 4'd15) ? 2'b01 : 2'b00;
   assign ForwardBE = (RegWriteM && WA3M == Ra2E && Ra2E != 4'd15) ? 2'b10 :
                      (RegWriteW && WA3W == Ra2E && Ra2E != 4'd15) ? 2'b01 : 2'b00;
   assign ldr_stall = MemtoRegE && (WA3E == Ra1D || WA3E == Ra2D);
   assign pc_pend   = PCSrcD || PCSrcE || PCSrcM;
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mc_stall  = 1'b0;
      case (state)
         IDLE: if (MultiCycleE && MC_EN) begin
            mc_stall  = 1'b1;
            cnt_nxt   = LOAD;
            state_nxt = (MC_LAT == 2) ? DONE : BUSY;
         end
         BUSY: begin
            mc_stall  = 1'b1;
            cnt_nxt   = cnt - 4'd1;
            state_nxt = (cnt == 4'd1) ? DONE : BUSY;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   // a frozen E/D cannot be flushed, so load-use and branch flushes wait for DONE
   assign StallF = ldr_stall || pc_pend || mc_stall;
   assign StallD = ldr_stall || mc_stall;
   assign StallE = mc_stall;
   assign FlushD = (pc_pend || PCSrcW) && !mc_stall;
   assign FlushE = (ldr_stall || BranchTakenE) && !mc_stall;
   assign FlushM = mc_stall;
   assign McBusy = state != IDLE;
`ifdef HAZ_PERF_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         LdrStallCnt <= '0;
         McStallCnt  <= '0;
         FlushCnt    <= '0;
      end else begin
         if (ldr_stall && !mc_stall && !(&LdrStallCnt)) LdrStallCnt <= LdrStallCnt + CNT_W'(1);
         if (mc_stall && !(&McStallCnt)) McStallCnt <= McStallCnt + CNT_W'(1);
         if ((FlushD || FlushE) && !(&FlushCnt)) FlushCnt <= FlushCnt + CNT_W'(1);
      end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic against an occupancy-based reference model.
module tb_hazard_ctrl;
   localparam int MC_LAT = 4;
   localparam int CNT_W  = 16;
   logic       clk, reset;
   logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W;
   logic       RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MultiCycleE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
   int         n_cmp = 0, n_bad = 0;
`ifdef HAZ_PERF_EN
   logic [CNT_W-1:0] LdrStallCnt, McStallCnt, FlushCnt;
`endif

   hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
      .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE), .MultiCycleE(MultiCycleE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .McBusy(McBusy)
`ifdef HAZ_PERF_EN
      , .LdrStallCnt(LdrStallCnt), .McStallCnt(McStallCnt), .FlushCnt(FlushCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] ref_fwd(input logic [3:0] ra, input logic rwm, input logic [3:0] wm,
                                          input logic rww, input logic [3:0] ww);
      if (ra == 4'd15) return 2'b00;
      if (rwm && wm == ra) return 2'b10;
      if (rww && ww == ra) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] pick_reg();
      int v = $urandom_range(0, 4);
      return (v == 4) ? 4'd15 : 4'(v);
   endfunction

   task automatic clear_inputs();
      {Ra1D, Ra2D, Ra1E, Ra2E, WA3E, WA3M, WA3W} = '0;
      {RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MultiCycleE} = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_inputs();
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy} !== 11'b0) begin
         n_bad++;
         $display("FAIL reset_outputs got %b exp 0",
                  {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy});
      end
`ifdef HAZ_PERF_EN
      n_cmp++;
      if ({LdrStallCnt, McStallCnt, FlushCnt} !== '0) begin
         n_bad++;
         $display("FAIL reset_counters got %0d %0d %0d exp 0", LdrStallCnt, McStallCnt, FlushCnt);
      end
`endif
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy} !== 11'b0) begin
         n_bad++;
         $display("FAIL post_reset_idle got %b exp 0",
                  {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy});
      end
   endtask

   task automatic test_forward();
      @(negedge clk);
      clear_inputs();
      Ra1E = 4'd3; Ra2E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1; WA3W = 4'd3; RegWriteW = 1'b1;
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE} !== 4'b1010) begin
         n_bad++; $display("FAIL fwd_m_priority got %b exp 1010", {ForwardAE, ForwardBE});
      end
      RegWriteM = 1'b0;
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE} !== 4'b0101) begin
         n_bad++; $display("FAIL fwd_w got %b exp 0101", {ForwardAE, ForwardBE});
      end
      Ra1E = 4'd15; WA3W = 4'd15; Ra2E = 4'd7;
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE} !== 4'b0000) begin
         n_bad++; $display("FAIL fwd_r15_or_miss got %b exp 0000", {ForwardAE, ForwardBE});
      end
      clear_inputs();
   endtask

   task automatic test_ldr();
      @(negedge clk);
      clear_inputs();
      MemtoRegE = 1'b1; WA3E = 4'd5; Ra2D = 4'd5; Ra1D = 4'd2;
      #1;
      n_cmp++;
      if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
         n_bad++; $display("FAIL ldr_use got %b exp 1110", {StallF, StallD, FlushE, StallE});
      end
      @(negedge clk);
      clear_inputs();
      #1;
      n_cmp++;
      if ({StallF, StallD, FlushE, StallE} !== 4'b0000) begin
         n_bad++; $display("FAIL ldr_use_release got %b exp 0000", {StallF, StallD, FlushE, StallE});
      end
   endtask

   task automatic test_multicycle();
      for (int i = 0; i <= MC_LAT; i++) begin
         @(negedge clk);
         clear_inputs();
         MultiCycleE = (i < MC_LAT);
         #1;
         n_cmp++;
         if ({StallF, StallD, StallE, FlushM, McBusy} !== {{4{i < MC_LAT - 1}}, (i > 0 && i < MC_LAT)}) begin
            n_bad++;
            $display("FAIL mc_seq i=%0d got %b exp %b", i, {StallF, StallD, StallE, FlushM, McBusy},
                     {{4{i < MC_LAT - 1}}, (i > 0 && i < MC_LAT)});
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= 2 * MC_LAT; i++) begin
         @(negedge clk);
         clear_inputs();
         MultiCycleE = (i < 2 * MC_LAT);
         #1;
         n_cmp++;
         if ({StallE, FlushM, McBusy} !== {{2{(i % MC_LAT) != MC_LAT - 1 && i < 2 * MC_LAT}}, (i % MC_LAT) != 0}) begin
            n_bad++;
            $display("FAIL b2b i=%0d got %b exp %b", i, {StallE, FlushM, McBusy},
                     {{2{(i % MC_LAT) != MC_LAT - 1 && i < 2 * MC_LAT}}, (i % MC_LAT) != 0});
         end
      end
   endtask

   task automatic test_pc_march();
      logic [3:0] pulse;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         clear_inputs();
         pulse = 4'b1000;
         {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = (i < 4) ? pulse >> i : 4'b0000;
         #1;
         n_cmp++;
         if ({StallF, StallD, FlushD} !== {i < 3, 1'b0, i < 4}) begin
            n_bad++;
            $display("FAIL pc_march i=%0d got %b exp %b", i, {StallF, StallD, FlushD}, {i < 3, 1'b0, i < 4});
         end
      end
   endtask

   task automatic test_branch_busy();
      for (int i = 0; i <= MC_LAT; i++) begin
         @(negedge clk);
         clear_inputs();
         MultiCycleE = (i < MC_LAT);
         BranchTakenE = 1'b1;
         #1;
         n_cmp++;
         if (FlushE !== (i >= MC_LAT - 1)) begin
            n_bad++; $display("FAIL branch_busy i=%0d got %b exp %b", i, FlushE, i >= MC_LAT - 1);
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      @(negedge clk) MultiCycleE = 1'b1;
      @(negedge clk);
      #2;
      n_cmp++;
      if (McBusy !== 1'b1) begin
         n_bad++; $display("FAIL mid_busy_before_reset got %b exp 1", McBusy);
      end
      reset = 1'b0;
      MultiCycleE = 1'b0;
      #1;
      n_cmp++;
      if ({StallF, StallD, StallE, FlushM, McBusy} !== 5'b0) begin
         n_bad++; $display("FAIL reset_mid got %b exp 00000", {StallF, StallD, StallE, FlushM, McBusy});
      end
`ifdef HAZ_PERF_EN
      n_cmp++;
      if (McStallCnt !== '0) begin
         n_bad++; $display("FAIL reset_mid_cnt got %0d exp 0", McStallCnt);
      end
`endif
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i <= MC_LAT; i++) begin
         @(negedge clk);
         MultiCycleE = (i < MC_LAT);
      end
      @(negedge clk);
      clear_inputs();
      #1;
      n_cmp++;
      if ({StallE, McBusy} !== 2'b00) begin
         n_bad++; $display("FAIL after_op_idle got %b exp 00", {StallE, McBusy});
      end
`ifdef HAZ_PERF_EN
      n_cmp++;
      if (McStallCnt !== CNT_W'(MC_LAT - 1)) begin
         n_bad++; $display("FAIL mc_stall_cnt got %0d exp %0d", McStallCnt, MC_LAT - 1);
      end
`endif
   endtask

   task automatic test_random();
      int occ = 0;
      int m_ldr = 0, m_mc = 0, m_fl = 0;
      logic ms, ld, pp, e_fd, e_fe;
      @(negedge clk);
      clear_inputs();
      reset = 1'b0;
      #1 reset = 1'b1;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         Ra1D = pick_reg(); Ra2D = pick_reg(); Ra1E = pick_reg(); Ra2E = pick_reg();
         WA3E = pick_reg(); WA3M = pick_reg(); WA3W = pick_reg();
         RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
         MemtoRegE = ($urandom_range(0, 3) == 0);
         PCSrcD = ($urandom_range(0, 5) == 0); PCSrcE = ($urandom_range(0, 5) == 0);
         PCSrcM = ($urandom_range(0, 5) == 0); PCSrcW = ($urandom_range(0, 5) == 0);
         BranchTakenE = ($urandom_range(0, 4) == 0);
         MultiCycleE = (occ > 0 && occ < MC_LAT - 1) ? 1'b1 : ($urandom_range(0, 5) == 0);
         #1;
         ms = (occ > 0 || MultiCycleE) && occ < MC_LAT - 1;
         ld = MemtoRegE && (WA3E == Ra1D || WA3E == Ra2D);
         pp = PCSrcD || PCSrcE || PCSrcM;
         e_fd = (pp || PCSrcW) && !ms;
         e_fe = (ld || BranchTakenE) && !ms;
         n_cmp++;
         if (ForwardAE !== ref_fwd(Ra1E, RegWriteM, WA3M, RegWriteW, WA3W)) begin
            n_bad++; $display("FAIL rnd_fwdA c=%0d got %b exp %b", c, ForwardAE, ref_fwd(Ra1E, RegWriteM, WA3M, RegWriteW, WA3W));
         end
         n_cmp++;
         if (ForwardBE !== ref_fwd(Ra2E, RegWriteM, WA3M, RegWriteW, WA3W)) begin
            n_bad++; $display("FAIL rnd_fwdB c=%0d got %b exp %b", c, ForwardBE, ref_fwd(Ra2E, RegWriteM, WA3M, RegWriteW, WA3W));
         end
         n_cmp++;
         if ({StallF, StallD, StallE, FlushD, FlushE, FlushM} !== {ld | pp | ms, ld | ms, ms, e_fd, e_fe, ms}) begin
            n_bad++;
            $display("FAIL rnd_stall_flush c=%0d got %b exp %b", c, {StallF, StallD, StallE, FlushD, FlushE, FlushM},
                     {ld | pp | ms, ld | ms, ms, e_fd, e_fe, ms});
         end
         n_cmp++;
         if (McBusy !== (occ > 0)) begin
            n_bad++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, McBusy, occ > 0);
         end
`ifdef HAZ_PERF_EN
         n_cmp++;
         if ({LdrStallCnt, McStallCnt, FlushCnt} !== {CNT_W'(m_ldr), CNT_W'(m_mc), CNT_W'(m_fl)}) begin
            n_bad++;
            $display("FAIL rnd_counters c=%0d got %0d %0d %0d exp %0d %0d %0d", c, LdrStallCnt, McStallCnt, FlushCnt,
                     m_ldr, m_mc, m_fl);
         end
         if (ld && !ms && m_ldr < (1 << CNT_W) - 1) m_ldr++;
         if (ms && m_mc < (1 << CNT_W) - 1) m_mc++;
         if ((e_fd || e_fe) && m_fl < (1 << CNT_W) - 1) m_fl++;
`endif
         occ = ms ? occ + 1 : 0;
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_ldr();
      test_multicycle();
      test_back_to_back();
      test_pc_march();
      test_branch_busy();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
